// File: rtl/sar_pkg.sv
// Shared definitions for the SAR result reader slice.
// Holds default geometry/timing values and the serializer state type.
package sar_pkg;

  localparam int SAR_DATA_W      = 10;  // sar word and serial frame width
  localparam int SAR_FIFO_DEPTH  = 4;   // result FIFO entries (power of 2)
  localparam int SAR_CONV_PERIOD = 40;  // clk cycles between cnvst rises
  localparam int SAR_CNVST_HIGH  = 2;   // cnvst high time in clk cycles
  localparam int SAR_GAP_CYC     = 2;   // cs_n-high cycles between frames

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/sar_result_fifo.sv
// Small synchronous FIFO buffering captured SAR words.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, din      write request and data; ignored when full
//   pop, dout      read request; dout shows the head word combinationally
//   count          words held
//   full, empty    status flags
// The head word is read combinationally so the serializer can load it on
// the same edge it pops, keeping the eoc-to-frame latency at two cycles.
module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int DATA_W = SAR_DATA_W,
  parameter int DEPTH  = SAR_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage needs no reset: resetting the pointers and count empties it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sar_result_reader.sv
// Reader side of the SAR conversion interface.
// Generates periodic cnvst pulses, captures the sar word on each eoc rise,
// buffers words in a FIFO and streams them MSB-first over cs_n/sclk/sdo.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       runs the cnvst generator
//   sar, eoc     conversion result and end-of-conversion (same clock domain)
//   clr_ovf      clears the sticky overflow flag
//   cnvst        conversion start pulse
//   cs_n, sclk, sdo  serial frame select (active low), clock (idle low), data
//   overflow     sticky: a word was dropped because the FIFO was full
//   fifo_count   words currently held in the FIFO
module sar_result_reader
  import sar_pkg::*;
#(
  parameter int DATA_W      = SAR_DATA_W,
  parameter int FIFO_DEPTH  = SAR_FIFO_DEPTH,
  parameter int CONV_PERIOD = SAR_CONV_PERIOD,
  parameter int CNVST_HIGH  = SAR_CNVST_HIGH,
  parameter int GAP_CYC     = SAR_GAP_CYC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             sar,
  input  logic                          eoc,
  input  logic                          clr_ovf,
  output logic                          cnvst,
  output logic                          cs_n,
  output logic                          sclk,
  output logic                          sdo,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W  = $clog2(CONV_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(CNVST_HIGH);
  // hcnt counts sclk half-periods in SHIFT and idle cycles in GAP.
  localparam int HC_MAX = (2 * DATA_W > GAP_CYC) ? 2 * DATA_W : GAP_CYC;
  localparam int HC_W   = $clog2(HC_MAX + 1);
  localparam logic [HC_W-1:0] HC_END   = HC_W'(2 * DATA_W);
  localparam logic [HC_W-1:0] GAP_LAST = HC_W'(GAP_CYC - 1);

  // ---------------- cnvst generator ----------------
  logic [CNT_W-1:0] cnt_reg;
  logic             cnvst_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      cnvst_reg <= 1'b0;
    end else if (enable) begin
      cnvst_reg <= (cnt_reg < CNT_HIGH);
      cnt_reg   <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end else begin
      // Parking at zero makes a re-enable start with cnvst high.
      cnt_reg   <= '0;
      cnvst_reg <= 1'b0;
    end
  end

  assign cnvst = cnvst_reg;

  // ---------------- eoc capture and overflow ----------------
  logic eoc_d_reg;
  logic overflow_reg;
  logic capture;
  logic push;
  logic drop;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  // Full is judged on the pre-pop count, so a pop on the same edge
  // does not make room for the incoming word.
  assign capture = eoc & ~eoc_d_reg;
  assign push    = capture & ~fifo_full;
  assign drop    = capture & fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoc_d_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      eoc_d_reg <= eoc;
      if (drop)         overflow_reg <= 1'b1;  // a drop beats a clear
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

  sar_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sar),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- serializer FSM ----------------
  ser_state_t        state_reg,  state_next;
  logic [DATA_W-1:0] shreg_reg,  shreg_next;
  logic [HC_W-1:0]   hcnt_reg,   hcnt_next;
  logic              cs_n_reg,   cs_n_next;
  logic              sclk_reg,   sclk_next;
  logic              sdo_reg,    sdo_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      hcnt_reg  <= '0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b0;
      sdo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      hcnt_reg  <= hcnt_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      sdo_reg   <= sdo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    hcnt_next  = hcnt_reg;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    sdo_next   = sdo_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = fifo_dout;
          cs_n_next  = 1'b0;
          sdo_next   = fifo_dout[DATA_W-1];
          sclk_next  = 1'b0;
          hcnt_next  = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // One extra cycle after the last falling sclk keeps cs_n low
        // for 2*DATA_W+1 cycles in total.
        if (hcnt_reg == HC_END) begin
          cs_n_next  = 1'b1;
          sdo_next   = 1'b0;
          sclk_next  = 1'b0;
          hcnt_next  = '0;
          state_next = GAP;
        end else begin
          sclk_next = ~sclk_reg;
          hcnt_next = hcnt_reg + HC_W'(1);
          // Data changes on the falling sclk so it is stable at the rise.
          if (sclk_reg) begin
            shreg_next = {shreg_reg[DATA_W-2:0], 1'b0};
            sdo_next   = shreg_reg[DATA_W-2];
          end
        end
      end
      GAP: begin
        if (hcnt_reg == GAP_LAST) begin
          hcnt_next  = '0;
          state_next = IDLE;
        end else begin
          hcnt_next = hcnt_reg + HC_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cs_n = cs_n_reg;
  assign sclk = sclk_reg;
  assign sdo  = sdo_reg;

endmodule

// File: tb/tb_sar_result_reader.sv
// Directed testbench for sar_result_reader: reset values, cnvst timing,
// eoc capture, serial frame contents/length, overflow and mid-frame reset.
module tb_sar_result_reader;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [9:0] sar;
  logic       eoc;
  logic       clr_ovf;
  logic       cnvst;
  logic       cs_n;
  logic       sclk;
  logic       sdo;
  logic       overflow;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  // Frames decoded from the serial pins.
  logic [9:0] q_data [$];
  int         q_bits [$];
  int         q_low  [$];

  sar_result_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sar        (sar),
    .eoc        (eoc),
    .clr_ovf    (clr_ovf),
    .cnvst      (cnvst),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .sdo        (sdo),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial receiver: samples sdo on each sclk rise, measures cs_n low time.
  initial begin
    logic [9:0] rx;
    int nb;
    int lowc;
    bit in_frame;
    bit sclk_prev;
    rx = '0; nb = 0; lowc = 0; in_frame = 0; sclk_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
      end else if (!cs_n) begin
        if (!in_frame) begin
          in_frame = 1; rx = '0; nb = 0; lowc = 0;
        end
        lowc++;
        if (sclk && !sclk_prev) begin
          rx = {rx[8:0], sdo};
          nb++;
        end
      end else if (in_frame) begin
        in_frame = 0;
        q_data.push_back(rx);
        q_bits.push_back(nb);
        q_low.push_back(lowc);
      end
      sclk_prev = sclk;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_timeout", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [9:0] exp);
    if (q_data.size() > 0) begin
      chk({tag, "_data"}, 32'(q_data.pop_front()), 32'(exp));
      chk({tag, "_bits"}, 32'(q_bits.pop_front()), 32'd10);
      chk({tag, "_cs_low"}, 32'(q_low.pop_front()), 32'd21);
    end
  endtask

  task automatic eoc_pulse(input logic [9:0] val);
    sar = val;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sar = '0; eoc = 1'b0; clr_ovf = 1'b0;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_cnvst", 32'(cnvst), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: cnvst high for cycles with cnt 0,1 of every 40
    enable = 1'b1;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      chk($sformatf("cnvst_run_%0d", k), 32'(cnvst), 32'(((k - 1) % 40) < 2));
    end
    enable = 1'b0;  // cnvst currently high (k=82)
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      chk($sformatf("cnvst_off_%0d", k), 32'(cnvst), 32'd0);
    end

    // 3: single capture and frame
    sar = 10'h2A5;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    chk("t3_count_push", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("t3_count_pop", 32'(fifo_count), 32'd0);
    chk("t3_cs_low", 32'(cs_n), 32'd0);
    chk("t3_sdo_msb", 32'(sdo), 32'd1);
    wait_frames(1, 60);
    check_frame("t3", 10'h2A5);

    // 4: eoc held high 5 cycles gives one capture
    repeat (5) @(negedge clk);
    sar = 10'h155;
    eoc = 1'b1;
    repeat (5) @(negedge clk);
    eoc = 1'b0;
    wait_frames(1, 60);
    check_frame("t4", 10'h155);
    repeat (60) @(negedge clk);
    chk("t4_no_extra", 32'(q_data.size()), 32'd0);
    chk("t4_count", 32'(fifo_count), 32'd0);

    // 5: six pulses, sixth dropped; clr_ovf on the drop edge loses
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) clr_ovf = 1'b1;
      sar = 10'(i);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      clr_ovf = 1'b0;
      @(negedge clk);
    end
    chk("t5_count_full", 32'(fifo_count), 32'd4);
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    @(negedge clk);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    wait_frames(5, 300);
    for (int i = 1; i <= 5; i++) begin
      check_frame($sformatf("t5_f%0d", i), 10'(i));
    end
    repeat (40) @(negedge clk);
    chk("t5_no_word6", 32'(q_data.size()), 32'd0);
    chk("t5_count_end", 32'(fifo_count), 32'd0);

    // 6: reset during SHIFT with two words queued
    eoc_pulse(10'h3FF);
    eoc_pulse(10'h0AA);
    eoc_pulse(10'h0BB);
    repeat (2) @(negedge clk);
    chk("t6_in_frame", 32'(cs_n), 32'd0);
    chk("t6_queued", 32'(fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs_n", 32'(cs_n), 32'd1);
    chk("t6_sclk", 32'(sclk), 32'd0);
    chk("t6_sdo", 32'(sdo), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_cnvst", 32'(cnvst), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("t6_no_frame", 32'(q_data.size()), 32'd0);
    chk("t6_cs_idle", 32'(cs_n), 32'd1);
    chk("t6_count_after", 32'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
